// File: rtl/mau_pkg.sv
// mau_pkg: shared types and helpers for the memory-stage load/store engine.
package mau_pkg;

   localparam int unsigned XLEN = 32;

   // FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mau_state_e;

   // funct3 access encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // access size carried in funct3[1:0]
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;

   // Byte enables from access size and the low address bits
   function automatic logic [3:0] be_from_size(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         SZ_B:    return 4'b0001 << lo;
         SZ_H:    return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Only the five defined access encodings are legal
   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Half needs addr[0]=0, word needs addr[1:0]=0
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         SZ_B:    return 1'b0;
         SZ_H:    return lo[0];
         default: return (lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational store-lane replication and load extraction/extension.
module mau_lane_align
   import mau_pkg::*;
(
   input  logic [2:0]      st_funct3_i,
   input  logic [1:0]      st_addr_lo_i,
   input  logic [XLEN-1:0] st_data_i,
   output logic [XLEN-1:0] st_wdata_o,
   output logic [3:0]      st_be_o,
   input  logic [2:0]      ld_funct3_i,
   input  logic [1:0]      ld_addr_lo_i,
   input  logic [XLEN-1:0] ld_rdata_i,
   output logic [XLEN-1:0] ld_data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Store direction: replicate the datum over every lane it may land in
   always_comb begin
      st_be_o    = be_from_size(st_funct3_i, st_addr_lo_i);
      st_wdata_o = st_data_i;
      case (st_funct3_i[1:0])
         SZ_B:    st_wdata_o = {4{st_data_i[7:0]}};
         SZ_H:    st_wdata_o = {2{st_data_i[15:0]}};
         default: st_wdata_o = st_data_i;
      endcase
   end

   // Load direction: pick the addressed lane, then sign- or zero-extend
   always_comb begin
      byte_v = ld_rdata_i[7:0];
      case (ld_addr_lo_i)
         2'd0:    byte_v = ld_rdata_i[7:0];
         2'd1:    byte_v = ld_rdata_i[15:8];
         2'd2:    byte_v = ld_rdata_i[23:16];
         default: byte_v = ld_rdata_i[31:24];
      endcase
      half_v = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
      case (ld_funct3_i)
         F3_B:    ld_data_o = {{24{byte_v[7]}}, byte_v};
         F3_BU:   ld_data_o = {24'd0, byte_v};
         F3_H:    ld_data_o = {{16{half_v[15]}}, half_v};
         F3_HU:   ld_data_o = {16'd0, half_v};
         F3_W:    ld_data_o = ld_rdata_i;
         default: ld_data_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine, one req/ack transaction per access.
// Optional feature: define MAU_MISALIGN_TRAP_EN to trap misaligned accesses
// (adds trap/trap_pc ports); otherwise misaligned accesses issue as-is.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] mem_addr_in,
   input  logic [XLEN-1:0] store_data_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   output logic            stall,
   output logic [XLEN-1:0] ld_data_out,
   output logic            bus_err,
   output logic            dm_req,
   output logic            dm_we,
   output logic [XLEN-1:0] dm_addr,
   output logic [XLEN-1:0] dm_wdata,
   output logic [3:0]      dm_be,
   input  logic [XLEN-1:0] dm_rdata,
   input  logic            dm_ack
`ifdef MAU_MISALIGN_TRAP_EN
   ,
   output logic            trap,
   output logic [XLEN-1:0] trap_pc
`endif
);

   localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

   mau_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]      lo_q;
   logic [2:0]      f3_q;
   logic            req_q, we_q, bus_err_q;
   logic [XLEN-1:0] addr_q, wdata_q, ld_q;
   logic [3:0]      be_q;
   logic [XLEN-1:0] wdata_d, ld_d;
   logic [3:0]      be_d;
   logic            op_c;

   assign op_c = mem_read | mem_write;

   mau_lane_align u_align (
      .st_funct3_i  (funct3),
      .st_addr_lo_i (mem_addr_in[1:0]),
      .st_data_i    (store_data_in),
      .st_wdata_o   (wdata_d),
      .st_be_o      (be_d),
      .ld_funct3_i  (f3_q),
      .ld_addr_lo_i (lo_q),
      .ld_rdata_i   (dm_rdata),
      .ld_data_o    (ld_d)
   );

`ifdef MAU_MISALIGN_TRAP_EN
   logic            trap_q;
   logic [XLEN-1:0] trap_pc_q;
   assign trap    = trap_q;
   assign trap_pc = trap_pc_q;
`else
   logic unused_pc;
   assign unused_pc = ^pc_in;
`endif

   // Access FSM with registered request fields, timeout counter and pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         lo_q      <= '0;
         f3_q      <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         bus_err_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         ld_q      <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
         trap_q    <= 1'b0;
         trap_pc_q <= '0;
`endif
      end else begin
         bus_err_q <= 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
         trap_q    <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (op_c) begin
                  if (!f3_legal(funct3)) begin
                     state_q   <= ST_DONE;
                     bus_err_q <= 1'b1;
                     ld_q      <= '0;
                  end
`ifdef MAU_MISALIGN_TRAP_EN
                  else if (misaligned(funct3, mem_addr_in[1:0])) begin
                     state_q   <= ST_DONE;
                     trap_q    <= 1'b1;
                     trap_pc_q <= pc_in;
                     if (!mem_write) ld_q <= '0;
                  end
`endif
                  else begin
                     state_q <= ST_BUSY;
                     req_q   <= 1'b1;
                     we_q    <= mem_write;
                     addr_q  <= {mem_addr_in[XLEN-1:2], 2'b00};
                     wdata_q <= wdata_d;
                     be_q    <= be_d;
                     lo_q    <= mem_addr_in[1:0];
                     f3_q    <= funct3;
                     cnt_q   <= '0;
                  end
               end
            end
            ST_BUSY: begin
               if (dm_ack) begin
                  if (!we_q) ld_q <= ld_d;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  state_q <= ST_DONE;
               end else if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1))) begin
                  req_q     <= 1'b0;
                  we_q      <= 1'b0;
                  bus_err_q <= 1'b1;
                  ld_q      <= '0;
                  state_q   <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Freeze the pipeline from op detection until the transaction finishes
   assign stall = ((state_q == ST_IDLE) & op_c) | (state_q == ST_BUSY);

   assign dm_req      = req_q;
   assign dm_we       = we_q;
   assign dm_addr     = addr_q;
   assign dm_wdata    = wdata_q;
   assign dm_be       = be_q;
   assign ld_data_out = ld_q;
   assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven checks of mem_access_unit plus reset and ack corner cases.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_addr_in = '0, store_data_in = '0, pc_in = '0, dm_rdata = '0;
   logic        mem_read = 1'b0, mem_write = 1'b0, dm_ack = 1'b0;
   logic [2:0]  funct3 = '0;
   logic        stall, bus_err, dm_req, dm_we;
   logic [31:0] ld_data_out, dm_addr, dm_wdata;
   logic [3:0]  dm_be;
`ifdef MAU_MISALIGN_TRAP_EN
   logic        trap;
   logic [31:0] trap_pc;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .mem_addr_in(mem_addr_in), .store_data_in(store_data_in),
      .pc_in(pc_in), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
      .stall(stall), .ld_data_out(ld_data_out), .bus_err(bus_err), .dm_req(dm_req),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack)
`ifdef MAU_MISALIGN_TRAP_EN
      , .trap(trap), .trap_pc(trap_pc)
`endif
   );

   typedef struct {
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, sdata, rdata, pc;
      int          delay;
      logic        e_req;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata, e_ld;
      int          e_stall;
      logic        e_err, e_trap;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int delay, input logic e_req,
                               input logic [31:0] e_addr, input logic [3:0] e_be,
                               input logic [31:0] e_wdata, input logic [31:0] e_ld,
                               input int e_stall, input logic e_err, input logic e_trap);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
      v.pc = 32'h40; v.delay = delay; v.e_req = e_req; v.e_addr = e_addr; v.e_be = e_be;
      v.e_wdata = e_wdata; v.e_ld = e_ld; v.e_stall = e_stall; v.e_err = e_err; v.e_trap = e_trap;
      return v;
   endfunction

   // Drive one op in IDLE, ack after v.delay extra BUSY cycles, check through DONE
   task automatic run_vec(input int idx, input vec_t v);
      int stall_cnt, busy_cnt;
      bit done, req_seen;
      stall_cnt = 0; busy_cnt = 0; done = 0; req_seen = 0;
      @(posedge clk); #1;
      mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; mem_addr_in = v.addr;
      store_data_in = v.sdata; pc_in = v.pc; dm_rdata = v.rdata; dm_ack = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (stall) stall_cnt++;
         if (dm_req) begin
            busy_cnt++;
            if (!req_seen) begin
               chk($sformatf("v%0d dm_addr", idx), dm_addr, v.e_addr);
               chk($sformatf("v%0d dm_be", idx), 32'(dm_be), 32'(v.e_be));
               chk($sformatf("v%0d dm_wdata", idx), dm_wdata, v.e_wdata);
               chk($sformatf("v%0d dm_we", idx), 32'(dm_we), 32'(v.wr));
            end
            req_seen = 1;
         end
         if (!stall) begin
            done = 1;
            chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(v.e_err));
            chk($sformatf("v%0d ld_data_out", idx), ld_data_out, v.e_ld);
`ifdef MAU_MISALIGN_TRAP_EN
            chk($sformatf("v%0d trap", idx), 32'(trap), 32'(v.e_trap));
            if (v.e_trap) chk($sformatf("v%0d trap_pc", idx), trap_pc, v.pc);
`endif
            mem_read = 1'b0; mem_write = 1'b0; dm_ack = 1'b0;
         end else begin
            dm_ack = dm_req && (busy_cnt == v.delay + 1);
         end
      end
      if (!done) begin
         chk($sformatf("v%0d completion", idx), 32'(done), 32'd1);
         mem_read = 1'b0; mem_write = 1'b0; dm_ack = 1'b0;
      end
      chk($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(v.e_stall));
      chk($sformatf("v%0d req_issued", idx), 32'(req_seen), 32'(v.e_req));
   endtask

   logic [31:0] last_ld;

   initial begin
      // rd wr f3 addr sdata rdata delay | req addr be wdata ld stall err trap
      vecs.push_back(mk(0,1,3'b010,32'h104,32'hDEADBEEF,0,0, 1,32'h104,4'b1111,32'hDEADBEEF,32'h0,2,0,0));
      vecs.push_back(mk(0,1,3'b000,32'h203,32'h000000A5,0,0, 1,32'h200,4'b1000,32'hA5A5A5A5,32'h0,2,0,0));
      vecs.push_back(mk(1,0,3'b000,32'h102,0,32'h12F03456,0, 1,32'h100,4'b0100,32'h0,32'hFFFFFFF0,2,0,0));
      vecs.push_back(mk(1,0,3'b100,32'h102,0,32'h12F03456,0, 1,32'h100,4'b0100,32'h0,32'h000000F0,2,0,0));
      vecs.push_back(mk(1,0,3'b001,32'h102,0,32'h80010000,3, 1,32'h100,4'b1100,32'h0,32'hFFFF8001,5,0,0));
      vecs.push_back(mk(0,1,3'b001,32'h106,32'h1234ABCD,0,1, 1,32'h104,4'b1100,32'hABCDABCD,32'hFFFF8001,3,0,0));
      vecs.push_back(mk(1,0,3'b101,32'h100,0,32'h12348765,0, 1,32'h100,4'b0011,32'h0,32'h00008765,2,0,0));
      vecs.push_back(mk(1,0,3'b010,32'h108,0,32'hCAFEF00D,2, 1,32'h108,4'b1111,32'h0,32'hCAFEF00D,4,0,0));
      vecs.push_back(mk(1,0,3'b011,32'h100,0,32'h0,0,        0,32'h0,4'b0000,32'h0,32'h0,1,1,0));
      vecs.push_back(mk(1,0,3'b000,32'h101,0,32'h00007F00,0, 1,32'h100,4'b0010,32'h0,32'h0000007F,2,0,0));
      vecs.push_back(mk(1,1,3'b111,32'h100,0,32'h0,0,        0,32'h0,4'b0000,32'h0,32'h0,1,1,0));
      vecs.push_back(mk(1,0,3'b000,32'h103,0,32'h9A000000,0, 1,32'h100,4'b1000,32'h0,32'hFFFFFF9A,2,0,0));
      vecs.push_back(mk(1,0,3'b010,32'h10C,0,32'h0,99,       1,32'h10C,4'b1111,32'h0,32'h0,5,1,0));
      vecs.push_back(mk(0,1,3'b000,32'h200,32'h123456FF,0,0, 1,32'h200,4'b0001,32'hFFFFFFFF,32'h0,2,0,0));
`ifdef MAU_MISALIGN_TRAP_EN
      vecs.push_back(mk(1,0,3'b010,32'h101,0,32'h11223344,0, 0,32'h0,4'b0000,32'h0,32'h0,1,0,1));
      last_ld = 32'h0;
`else
      vecs.push_back(mk(1,0,3'b010,32'h101,0,32'h11223344,0, 1,32'h100,4'b1111,32'h0,32'h11223344,2,0,0));
      last_ld = 32'h11223344;
`endif

      // reset state
      repeat (2) @(negedge clk);
      chk("rst dm_req", 32'(dm_req), 0);
      chk("rst dm_we", 32'(dm_we), 0);
      chk("rst dm_addr", dm_addr, 0);
      chk("rst dm_be", 32'(dm_be), 0);
      chk("rst dm_wdata", dm_wdata, 0);
      chk("rst ld_data_out", ld_data_out, 0);
      chk("rst bus_err", 32'(bus_err), 0);
      chk("rst stall", 32'(stall), 0);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // ack outside BUSY is ignored; ld_data_out holds
      @(posedge clk); #1;
      dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("idle_ack dm_req", 32'(dm_req), 0);
      chk("idle_ack stall", 32'(stall), 0);
      @(posedge clk); #1;
      dm_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack ld_hold", ld_data_out, last_ld);
      chk("idle_ack bus_err", 32'(bus_err), 0);

      // reset asserted mid-BUSY drops the request at once
      @(posedge clk); #1;
      mem_read = 1'b1; funct3 = 3'b010; mem_addr_in = 32'h110;
      @(negedge clk);
      @(negedge clk);
      chk("midrst dm_req_before", 32'(dm_req), 1);
      mem_read = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst dm_req", 32'(dm_req), 0);
      chk("midrst stall", 32'(stall), 0);
      chk("midrst ld_data_out", ld_data_out, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst no_done_err", 32'(bus_err), 0);
      chk("midrst still_idle", 32'(dm_req), 0);

      // recovery after reset
      run_vec(100, mk(1,0,3'b010,32'h110,0,32'h00000055,0, 1,32'h110,4'b1111,32'h0,32'h00000055,2,0,0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine that consumes the EX/MEM pipeline register outputs: ALU result as address, rs2 data as store data, and current PC. Converts each load/store into a single request/acknowledge transaction on the data-memory port, generates byte enables and store-lane replication, and sign- or zero-extends load data. Stalls the pipeline until the transaction completes.

## Interface
- ACK_TIMEOUT, 255: cycles in BUSY without `dm_ack` before abort; 0 disables timeout.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_addr_in` in 32: effective address, the ALU result from EX/MEM.
- `store_data_in` in 32: rs2 data from EX/MEM.
- `pc_in` in 32: PC of the instruction in MEM.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request; wins if both are high.
- `funct3` in 3: access size/sign; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `stall` out 1: freeze IF..EX/MEM.
- `ld_data_out` out 32: extended load data.
- `bus_err` out 1: one-cycle pulse on timeout or illegal funct3.
- `dm_req` out 1: memory request.
- `dm_we` out 1: write strobe.
- `dm_addr` out 32: word address, bits [1:0] = 0.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_be` out 4: byte enables.
- `dm_rdata` in 32: read data, valid with `dm_ack`.
- `dm_ack` in 1: transaction complete.
- `trap` out 1: misaligned trap pulse; present only under the macro.
- `trap_pc` out 32: PC of the trapping instruction; present only under the macro.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - With no op, stay in IDLE.
  - With `mem_read|mem_write`, register address, data, be, we, funct3 and pc, then go to BUSY.
  - Illegal funct3 (011/110/111): issue no request, go to DONE, pulse `bus_err`, set `ld_data_out`=0.
- **BUSY:**
  - `dm_req`=1, with addr/we/be/wdata held stable.
  - On a sampled `dm_ack`: a load captures the extended `dm_rdata` into `ld_data_out`; then go to DONE.
  - Timeout counter reaches ACK_TIMEOUT: go to DONE, pulse `bus_err`, set `ld_data_out`=0.
- **DONE:**
  - `stall`=0 for exactly one cycle; the pipeline advances.
  - Always returns to IDLE; the op inputs are not re-sampled in DONE.
- **stall** = (IDLE & (mem_read|mem_write)) | BUSY. This is combinational.
- **Store lanes:**
  - SB: be = 1<<addr[1:0], byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011, half replicated ×2.
  - SW: be = 1111.
- **Load extraction:** byte/half taken from the lane selected by addr[1:0]/addr[1]; B/H sign-extend, BU/HU zero-extend.
- **`dm_ack`** outside BUSY is ignored.
- **`ld_data_out`** holds its value until the next completed load.

## Timing
- **Reset values:** all outputs 0, state IDLE.
- **Reset mid-BUSY:** `dm_req` drops asynchronously and no completion is reported.
- **Minimum latency:** op in cycle N → `dm_req` in N+1 → ack in N+1 → DONE in N+2 with `ld_data_out` valid. Two stall cycles.
- **Each extra wait cycle** on `dm_ack` adds one stall cycle.
- **Timeout:** with ACK_TIMEOUT=T>0, abort occurs after T BUSY cycles with no ack; DONE follows in the next cycle.

## Configuration
- **MAU_MISALIGN_TRAP_EN defined:**
  - Misaligned accesses (H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0) issue no request.
  - The FSM goes IDLE→DONE and pulses `trap` with `trap_pc`=pc_in.
  - Loads set `ld_data_out`=0; stores write nothing.
- **Undefined:**
  - The `trap`/`trap_pc` ports are absent.
  - Misaligned accesses issue with lanes computed from the address bits as-is: a half at addr[0]=1 uses the addr[1] half-lane, a word ignores addr[1:0].

## Structure
- **`mau_pkg`:** state enum, funct3 size encodings, and a `be`-from-size function.
- **`mau_lane_align` sub-module (combinational):**
  - Store direction: wdata and be from size and addr[1:0].
  - Load direction: extraction and extension.
- **Top level:** FSM, registered request fields, timeout counter.

## Test plan
- **SW:** addr 0x104, data 0xDEADBEEF, ack in first BUSY cycle → `dm_addr` 0x104, be 1111, wdata 0xDEADBEEF; stall high 2 cycles.
- **SB:** addr 0x203, data 0x000000A5 → be 1000, wdata 0xA5A5A5A5.
- **LB / LBU:** addr 0x102, `dm_rdata` 0x12F0_3456 → LB gives 0xFFFFFFF0 and LBU gives 0x000000F0 (byte 2 = 0xF0).
- **LH with 3-cycle ack delay:** addr 0x102, `dm_rdata` 0x8001_0000 → `ld_data_out` 0xFFFF8001; stall high 5 cycles.
- **Timeout:** ACK_TIMEOUT=4, no ack → `bus_err` pulse in the cycle after the 4th BUSY cycle, `ld_data_out` 0; then `rst` asserted mid-BUSY on a second access → `dm_req` 0 immediately.
- **Misaligned LW, macro on:** LW addr 0x101, pc 0x40 → no `dm_req`, `trap` 1 cycle, `trap_pc` 0x40. Macro off: `dm_addr` 0x100, be 1111.
